tiger_dmem_controller: RTL and testbench
========================================

# tiger_dmem_controller

Sequences every load and store issued by the Tiger MIPS memory-access stage onto a single Avalon-MM data master port. Stalls the pipeline until the bus transaction completes. Generates byte enables and lane-replicated write data, and returns right-justified, zero-filled load data. Sign extension is performed downstream in the memory-access stage. Sits between the MA pipeline stage and the data-side interconnect.

## Interface
- `ADDR_W`, default 32: byte-address width of the Avalon port.

Ports:
- `clk`  in  1  sole clock
- `reset`  in  1  asynchronous, active-high reset
- `memRead`  in  1  MA-stage load request, level, held while `stallOut`=1
- `memWrite`  in  1  MA-stage store request, level, held while `stallOut`=1
- `mem8`  in  1  byte access; wins if `mem16` also set
- `mem16`  in  1  halfword access; neither set means word access
- `addr`  in  ADDR_W  byte address (execute-stage result)
- `storeData`  in  32  store data, right-justified
- `stallOut`  out  1  freeze the pipeline
- `memreaddata`  out  32  load data, right-justified, zero-filled
- `addrErr`  out  1  misaligned request, combinational
- `avm_address`  out  ADDR_W  word address, bits [1:0] forced to 0
- `avm_byteenable`  out  4  active lanes
- `avm_read`, `avm_write`  out  1  Avalon commands
- `avm_writedata`  out  32  store data replicated across lanes
- `avm_readdata`  in  32  read data
- `avm_waitrequest`  in  1  slave not ready
- `avm_readdatavalid`  in  1  read data returned

## Operation
- **Byte lanes:** little-endian; byte at `addr[1:0]`=k occupies lane k, bits [8k+7:8k].
- **Byte enables:**
  - byte: one-hot by `addr[1:0]`.
  - half: `4'b0011` if `addr[1]`=0, else `4'b1100`.
  - word: `4'b1111`.
- **Write data:**
  - byte: `{4{storeData[7:0]}}`.
  - half: `{2{storeData[15:0]}}`.
  - word: `storeData`.
- **Read extraction:** selected lane(s) shifted to bit 0, upper bits zero. Captured into `memreaddata` on the accepted `readdatavalid`.
- **Alignment:**
  - half with `addr[0]`=1 is misaligned; word with `addr[1:0]`≠0 is misaligned.
  - On a misaligned request in IDLE: `addrErr`=1, no bus command, no stall.
- **Both requests set:** `memRead`&`memWrite` performs a read only.
- **FSM states:** IDLE, CMD, RDATA, DONE.
  - IDLE: on an aligned request, register address, byte enables and write data, assert `avm_read` or `avm_write`, go to CMD.
  - CMD: hold all `avm_*` outputs stable while `avm_waitrequest`=1. When `avm_waitrequest`=0:
    - write → DONE.
    - read with `avm_readdatavalid` in the same cycle → capture, DONE.
    - read otherwise → RDATA.
    - `avm_read`/`avm_write` drop on the exit edge.
  - RDATA: wait for `avm_readdatavalid`, capture, go to DONE.
  - DONE: one cycle, inputs ignored (same instruction still presented), go to IDLE.
- **Stall:** `stallOut` = (IDLE & aligned request) | CMD | RDATA. `stallOut`=0 in DONE, so the pipeline advances with `memreaddata` valid.
- **Stray read data:** `avm_readdatavalid` outside RDATA/CMD-accept is ignored.

## Timing
- **Reset values (async, immediate):** state=IDLE; `avm_read`=`avm_write`=0; `avm_address`=0, `avm_byteenable`=0, `avm_writedata`=0; `memreaddata`=0. `stallOut` and `addrErr` follow their equations from IDLE.
- **Store, no waitrequest:** 2 stall cycles (IDLE, CMD), DONE on cycle 2.
- **Load, waitrequest=0, readdata latency 1:** 3 stall cycles; `memreaddata` valid from the DONE cycle until the next capture.
- **Waitrequest:** each waitrequest cycle adds one stall cycle. Each readdata-latency cycle beyond 1 adds one.
- **Reset mid-transaction:** bus commands drop immediately; a late `avm_readdatavalid` after reset is ignored; no reissue.
- **Back-to-back requests:** a new request is sampled in the IDLE cycle after DONE. Minimum 3 cycles per access.

## Structure
- Shared constants go in `tiger_defines.v`:
  - FSM state encoding (2 bits).
  - access-size encoding: BYTE, HALF, WORD.
- One combinational sub-module, `tiger_mem_lane_align`:
  - inputs: size, `addr[1:0]`, store data, read data.
  - outputs: byte enable, replicated write data, extracted read data, misalignment flag.
- FSM and registers stay in `tiger_dmem_controller`.

## Test plan
- **Byte store:** `mem8` write to `addr`=0x1003, `storeData`=0x000000A5, `waitrequest`=0 → `avm_address`=0x1000, `byteenable`=4'b1000, `writedata`=0xA5A5A5A5; `stallOut` high 2 cycles.
- **Half load:** `mem16` read at 0x2002, `readdata`=0xBEEF1234 returned 1 cycle after accept → `byteenable`=4'b1100, `memreaddata`=0x0000BEEF in DONE; 3 stall cycles.
- **Waitrequest hold:** word read with `waitrequest` high 4 cycles → address, byteenable and `avm_read` constant throughout; 7 stall cycles total.
- **Misaligned:** word read at 0x3001 → `addrErr`=1, `stallOut`=0, no `avm_read` pulse.
- **Reset mid-read:** assert `reset` in RDATA, then pulse `readdatavalid` with 0xFFFFFFFF → `avm_read`=0 at once, state IDLE, `memreaddata` stays 0.
- **Simultaneous requests:** `memRead`=`memWrite`=1, word at 0x4000 → only `avm_read` asserted, `avm_write` never.

Source files
------------

// File: rtl/tiger_dmem_controller_pkg.sv
// Shared encodings for the Tiger data-memory controller: FSM states,
// access sizes and bus widths.
package tiger_dmem_controller_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_RDATA = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  // Byte wins over halfword; neither flag means a full word.
  function automatic size_e decode_size(input logic mem8, input logic mem16);
    if (mem8)  return SZ_BYTE;
    if (mem16) return SZ_HALF;
    return SZ_WORD;
  endfunction

endpackage

// File: rtl/tiger_mem_lane_align.sv
// Little-endian lane steering: byte enables, lane-replicated store data,
// right-justified zero-filled load data and the misalignment flag.
module tiger_mem_lane_align
  import tiger_dmem_controller_pkg::*;
(
  input  size_e             size,
  input  logic [1:0]        offset,
  input  logic [DATA_W-1:0] store_data,
  input  logic [DATA_W-1:0] read_data,
  output logic [BE_W-1:0]   byteenable,
  output logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] load_data,
  output logic              misaligned
);

  logic [DATA_W-1:0] byte_shift;
  logic [DATA_W-1:0] half_shift;

  assign byte_shift = read_data >> {offset, 3'b000};
  assign half_shift = read_data >> {offset[1], 4'b0000};

  always_comb begin
    byteenable = '0;
    write_data = store_data;
    load_data  = '0;
    misaligned = 1'b0;
    case (size)
      SZ_BYTE: begin
        byteenable = BE_W'(4'b0001) << offset;
        write_data = {4{store_data[7:0]}};
        load_data  = {24'h0, byte_shift[7:0]};
      end
      SZ_HALF: begin
        byteenable = offset[1] ? 4'b1100 : 4'b0011;
        write_data = {2{store_data[15:0]}};
        load_data  = {16'h0, half_shift[15:0]};
        misaligned = offset[0];
      end
      default: begin
        byteenable = 4'b1111;
        write_data = store_data;
        load_data  = read_data;
        misaligned = |offset;
      end
    endcase
  end

endmodule

// File: rtl/tiger_dmem_controller.sv
// Sequences MA-stage loads/stores onto one Avalon-MM data master and stalls
// the pipeline until the bus transaction has completed.
module tiger_dmem_controller
  import tiger_dmem_controller_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic              mem8,
  input  logic              mem16,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] storeData,
  output logic              stallOut,
  output logic [DATA_W-1:0] memreaddata,
  output logic              addrErr,
  output logic [ADDR_W-1:0] avm_address,
  output logic [BE_W-1:0]   avm_byteenable,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest,
  input  logic              avm_readdatavalid
);

  state_e            state;
  size_e             req_size;
  size_e             held_size;
  size_e             cur_size;
  logic [1:0]        held_off;
  logic [1:0]        cur_off;
  logic              req;
  logic              misaligned;
  logic              go;
  logic [BE_W-1:0]   lane_be;
  logic [DATA_W-1:0] lane_wd;
  logic [DATA_W-1:0] lane_ld;

  assign req      = memRead | memWrite;
  assign req_size = decode_size(mem8, mem16);

  // Live request steers lanes in IDLE; the captured one is used afterwards.
  assign cur_size = (state == ST_IDLE) ? req_size : held_size;
  assign cur_off  = (state == ST_IDLE) ? addr[1:0] : held_off;

  tiger_mem_lane_align u_lane_align (
    .size       (cur_size),
    .offset     (cur_off),
    .store_data (storeData),
    .read_data  (avm_readdata),
    .byteenable (lane_be),
    .write_data (lane_wd),
    .load_data  (lane_ld),
    .misaligned (misaligned)
  );

  assign go       = (state == ST_IDLE) & req & ~misaligned;
  assign addrErr  = (state == ST_IDLE) & req & misaligned;
  assign stallOut = go | (state == ST_CMD) | (state == ST_RDATA);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      held_size      <= SZ_WORD;
      held_off       <= 2'b00;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_address    <= '0;
      avm_byteenable <= '0;
      avm_writedata  <= '0;
      memreaddata    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (go) begin
            held_size      <= req_size;
            held_off       <= addr[1:0];
            avm_address    <= {addr[ADDR_W-1:2], 2'b00};
            avm_byteenable <= lane_be;
            avm_writedata  <= lane_wd;
            // A load wins when both requests are raised together.
            avm_read       <= memRead;
            avm_write      <= memWrite & ~memRead;
            state          <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (!avm_waitrequest) begin
            avm_read  <= 1'b0;
            avm_write <= 1'b0;
            if (avm_write) begin
              state <= ST_DONE;
            end else if (avm_readdatavalid) begin
              memreaddata <= lane_ld;
              state       <= ST_DONE;
            end else begin
              state <= ST_RDATA;
            end
          end
        end
        ST_RDATA: begin
          if (avm_readdatavalid) begin
            memreaddata <= lane_ld;
            state       <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tiger_dmem_controller.sv
// Directed bench for tiger_dmem_controller: a byte-lane transaction model
// predicts every output each cycle; literal expectations pin key results.
module tb_tiger_dmem_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memRead = 1'b0;
  logic        memWrite = 1'b0;
  logic        mem8 = 1'b0;
  logic        mem16 = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] storeData = '0;
  logic        stallOut;
  logic [31:0] memreaddata;
  logic        addrErr;
  logic [31:0] avm_address;
  logic [3:0]  avm_byteenable;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata = '0;
  logic        avm_waitrequest = 1'b0;
  logic        avm_readdatavalid = 1'b0;

  tiger_dmem_controller #(.ADDR_W(32)) dut (
    .clk               (clk),
    .reset             (reset),
    .memRead           (memRead),
    .memWrite          (memWrite),
    .mem8              (mem8),
    .mem16             (mem16),
    .addr              (addr),
    .storeData         (storeData),
    .stallOut          (stallOut),
    .memreaddata       (memreaddata),
    .addrErr           (addrErr),
    .avm_address       (avm_address),
    .avm_byteenable    (avm_byteenable),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_readdata      (avm_readdata),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdatavalid (avm_readdatavalid)
  );

  always #5 clk = ~clk;

  // Model state: expected outputs for the current cycle.
  logic        exp_stall = 1'b0;
  logic        exp_err   = 1'b0;
  logic        exp_read  = 1'b0;
  logic        exp_write = 1'b0;
  logic [31:0] m_addr  = '0;
  logic [3:0]  m_be    = '0;
  logic [31:0] m_wd    = '0;
  logic [31:0] m_rdata = '0;

  // Hand-computed literal pins.
  int          lit_stall  = -1;
  bit          lit_rd_en  = 1'b0;
  logic [31:0] lit_rd     = '0;
  bit          lit_bus_en = 1'b0;
  logic [31:0] lit_addr   = '0;
  logic [3:0]  lit_be     = '0;
  logic [31:0] lit_wd     = '0;
  bit          lit_cmd    = 1'b0;
  bit          at_done    = 1'b0;

  int total = 0;
  int bad   = 0;
  int stall_cnt = 0;

  function automatic logic [3:0] mdl_be(input int nb, input logic [1:0] off);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)
      if (i >= int'(off) && i < int'(off) + nb) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] mdl_wd(input int nb, input logic [31:0] sd);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sd[8*(i % nb) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mdl_ld(input int nb, input logic [1:0] off, input logic [31:0] rd);
    logic [31:0] r;
    r = '0;
    for (int j = 0; j < nb; j++) r[8*j +: 8] = rd[8*(int'(off) + j) +: 8];
    return r;
  endfunction

  function automatic bit mdl_mis(input int nb, input logic [1:0] off);
    return (int'(off) % nb) != 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Single compare process, sampling on the falling edge.
  always @(negedge clk) begin
    chk("stallOut", 32'(stallOut), 32'(exp_stall));
    chk("addrErr", 32'(addrErr), 32'(exp_err));
    chk("avm_read", 32'(avm_read), 32'(exp_read));
    chk("avm_write", 32'(avm_write), 32'(exp_write));
    chk("avm_address", avm_address, m_addr);
    chk("avm_byteenable", 32'(avm_byteenable), 32'(m_be));
    chk("avm_writedata", avm_writedata, m_wd);
    chk("memreaddata", memreaddata, m_rdata);
    if (reset) stall_cnt = 0;
    else if (stallOut) stall_cnt++;
    if (lit_bus_en && lit_cmd) begin
      chk("lit_address", avm_address, lit_addr);
      chk("lit_byteenable", 32'(avm_byteenable), 32'(lit_be));
      chk("lit_writedata", avm_writedata, lit_wd);
    end
    if (at_done) begin
      if (lit_stall >= 0) chk("stall_cycles", 32'(stall_cnt), 32'(lit_stall));
      if (lit_rd_en) chk("lit_memreaddata", memreaddata, lit_rd);
      stall_cnt = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_lits();
    lit_stall = -1; lit_rd_en = 1'b0; lit_bus_en = 1'b0;
  endtask

  // One access from request to the cycle after it retires.
  task automatic access(input bit rd, input bit wr, input int nb, input logic [31:0] a,
                        input logic [31:0] sd, input int nwait, input int lat,
                        input logic [31:0] rdat);
    logic [1:0] off;
    bit mis;
    off = a[1:0];
    mis = mdl_mis(nb, off);
    memRead = rd; memWrite = wr; mem8 = (nb == 1); mem16 = (nb == 2);
    addr = a; storeData = sd;
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0;
    exp_err = mis; exp_stall = !mis; exp_read = 1'b0; exp_write = 1'b0;
    if (mis) begin
      at_done = 1'b1;
      step();
      at_done = 1'b0;
    end else begin
      step();
      m_addr = {a[31:2], 2'b00};
      m_be   = mdl_be(nb, off);
      m_wd   = mdl_wd(nb, sd);
      exp_err = 1'b0;
      for (int w = 0; w <= nwait; w++) begin
        exp_stall = 1'b1; exp_read = rd; exp_write = wr & !rd;
        avm_waitrequest = (w < nwait);
        lit_cmd = (w == 0);
        if (rd && lat == 0 && w == nwait) begin
          avm_readdatavalid = 1'b1; avm_readdata = rdat;
        end
        step();
      end
      avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; lit_cmd = 1'b0;
      if (rd && lat > 0) begin
        for (int l = 1; l <= lat; l++) begin
          exp_stall = 1'b1; exp_read = 1'b0; exp_write = 1'b0;
          avm_readdatavalid = (l == lat);
          avm_readdata = (l == lat) ? rdat : 32'hDEAD0000;
          step();
        end
        avm_readdatavalid = 1'b0;
      end
      exp_stall = 1'b0; exp_read = 1'b0; exp_write = 1'b0;
      if (rd) m_rdata = mdl_ld(nb, off, rdat);
      at_done = 1'b1;
      step();
      at_done = 1'b0;
    end
    memRead = 1'b0; memWrite = 1'b0; exp_stall = 1'b0; exp_err = 1'b0;
    clear_lits();
  endtask

  initial begin
    repeat (2) step();
    reset = 1'b0;
    step();

    // Byte store, lane 3.
    lit_stall = 2; lit_bus_en = 1'b1;
    lit_addr = 32'h0000_1000; lit_be = 4'b1000; lit_wd = 32'hA5A5_A5A5;
    access(1'b0, 1'b1, 1, 32'h0000_1003, 32'h0000_00A5, 0, 0, 32'h0);

    // Half load, upper lanes, latency 1.
    lit_stall = 3; lit_rd_en = 1'b1; lit_rd = 32'h0000_BEEF; lit_bus_en = 1'b1;
    lit_addr = 32'h0000_2000; lit_be = 4'b1100; lit_wd = 32'h0;
    access(1'b1, 1'b0, 2, 32'h0000_2002, 32'h0, 0, 1, 32'hBEEF_1234);

    // Word read held by 4 waitrequest cycles.
    lit_stall = 7; lit_rd_en = 1'b1; lit_rd = 32'h1234_5678;
    access(1'b1, 1'b0, 4, 32'h0000_5008, 32'h0, 4, 1, 32'h1234_5678);

    // Misaligned word read.
    lit_stall = 0;
    access(1'b1, 1'b0, 4, 32'h0000_3001, 32'h0, 0, 1, 32'h0);

    // Read and write together: read only, latency 2.
    lit_stall = 4; lit_rd_en = 1'b1; lit_rd = 32'hCAFE_F00D;
    access(1'b1, 1'b1, 4, 32'h0000_4000, 32'h5555_5555, 0, 2, 32'hCAFE_F00D);

    // Byte loads at several lanes, one with same-cycle data.
    lit_stall = 3; lit_rd_en = 1'b1; lit_rd = 32'h0000_0033;
    access(1'b1, 1'b0, 1, 32'h0000_1001, 32'h0, 0, 1, 32'h1122_3344);
    lit_stall = 2; lit_rd_en = 1'b1; lit_rd = 32'h0000_0044;
    access(1'b1, 1'b0, 1, 32'h0000_1000, 32'h0, 0, 0, 32'h1122_3344);
    lit_stall = 3; lit_rd_en = 1'b1; lit_rd = 32'h0000_00BB;
    access(1'b1, 1'b0, 1, 32'h0000_0F02, 32'h0, 0, 1, 32'hAABB_CCDD);

    // Half store with waitrequest, word store, misaligned half.
    lit_stall = 4; lit_bus_en = 1'b1;
    lit_addr = 32'h0000_0100; lit_be = 4'b0011; lit_wd = 32'hBEEF_BEEF;
    access(1'b0, 1'b1, 2, 32'h0000_0100, 32'h0000_BEEF, 2, 0, 32'h0);
    lit_stall = 2;
    access(1'b0, 1'b1, 4, 32'h0000_0200, 32'hDEAD_BEEF, 0, 0, 32'h0);
    lit_stall = 0;
    access(1'b0, 1'b1, 2, 32'h0000_0001, 32'h1234_5678, 0, 0, 32'h0);

    // Half load, lower lanes, latency 3.
    lit_stall = 5; lit_rd_en = 1'b1; lit_rd = 32'h0000_CCDD;
    access(1'b1, 1'b0, 2, 32'h0000_0004, 32'h0, 0, 3, 32'hAABB_CCDD);

    // Stray read data while idle must not disturb the last load.
    avm_readdatavalid = 1'b1; avm_readdata = 32'h9999_9999;
    step();
    avm_readdatavalid = 1'b0;
    step();

    // Reset while waiting for read data; the late data is dropped.
    memRead = 1'b1; mem8 = 1'b0; mem16 = 1'b0; addr = 32'h0000_6004;
    exp_stall = 1'b1;
    step();
    m_addr = 32'h0000_6004; m_be = 4'b1111; m_wd = mdl_wd(4, storeData);
    exp_read = 1'b1;
    step();
    reset = 1'b1; memRead = 1'b0;
    exp_stall = 1'b0; exp_read = 1'b0;
    m_addr = '0; m_be = '0; m_wd = '0; m_rdata = '0;
    step();
    reset = 1'b0;
    step();
    avm_readdatavalid = 1'b1; avm_readdata = 32'hFFFF_FFFF;
    step();
    avm_readdatavalid = 1'b0;
    repeat (2) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
